// File: rtl/dsi_crc_stream.sv
// Byte-parallel DSI long-packet payload CRC (x^16+x^12+x^5+1, reflected) with valid/ready framing.
// Define DSI_CRC_APPEND_EN to append the two CRC bytes to the outgoing stream.
module dsi_crc_stream #(
   parameter int          g_lanes    = 4,
   parameter logic [15:0] g_crc_init = 16'hFFFF
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic [8*g_lanes-1:0] snk_data_i,
   input  logic                 snk_valid_i,
   output logic                 snk_ready_o,
   input  logic                 snk_sop_i,
   input  logic                 snk_eop_i,
   input  logic [3:0]           snk_nbytes_i,
   output logic [8*g_lanes-1:0] src_data_o,
   output logic                 src_valid_o,
   input  logic                 src_ready_i,
   output logic                 src_sop_o,
   output logic                 src_eop_o,
   output logic [3:0]           src_nbytes_o,
   output logic [15:0]          crc_o,
   output logic                 crc_valid_o,
   output logic                 err_o
);

   localparam int          W      = 8 * g_lanes;
   localparam logic [3:0]  LANES4 = 4'(g_lanes);
   localparam logic [1:0]  ST_IDLE = 2'd0;
   localparam logic [1:0]  ST_PKT  = 2'd1;
`ifdef DSI_CRC_APPEND_EN
   localparam logic [1:0]  ST_TAIL = 2'd2;
`endif

   function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] r;
      r = c ^ {8'h00, b};
      for (int i = 0; i < 8; i++) begin
         r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
      end
      return r;
   endfunction

   logic [1:0]   state_q, state_d;
   logic [15:0]  crc_run_q, crc_run_d;
   logic [W-1:0] src_data_q, src_data_d;
   logic         src_valid_q, src_valid_d;
   logic         src_sop_q, src_sop_d;
   logic         src_eop_q, src_eop_d;
   logic [3:0]   src_nbytes_q, src_nbytes_d;
   logic [15:0]  crc_q, crc_d;
   logic         crc_valid_q, crc_valid_d;
   logic         err_q, err_d;
`ifdef DSI_CRC_APPEND_EN
   logic [15:0]  tail_q, tail_d;
   logic [1:0]   tail_cnt_q, tail_cnt_d;
`endif

   logic         out_free;
   logic         accept;
   logic [3:0]   n_eff;
   logic [3:0]   n_lim;
   logic [15:0]  crc_base;
   logic [15:0]  crc_fold;

   assign out_free = !src_valid_q || src_ready_i;
`ifdef DSI_CRC_APPEND_EN
   assign snk_ready_o = out_free && (state_q != ST_TAIL);
`else
   assign snk_ready_o = out_free;
`endif
   assign accept = snk_valid_i && snk_ready_o;

   // Over-range byte counts are treated as a full beat.
   assign n_eff    = (snk_nbytes_i > LANES4) ? LANES4 : snk_nbytes_i;
   assign n_lim    = snk_eop_i ? n_eff : LANES4;
   assign crc_base = (state_q == ST_PKT && !snk_sop_i) ? crc_run_q : g_crc_init;

   always_comb begin
      crc_fold = crc_base;
      for (int k = 0; k < g_lanes; k++) begin
         if (4'(k) < n_lim) crc_fold = crc_byte(crc_fold, snk_data_i[8*k +: 8]);
      end
   end

   always_comb begin
      // NOTE: every next-state signal gets a default first, so no path leaves one unassigned (no latches).
      state_d      = state_q;
      crc_run_d    = crc_run_q;
      src_data_d   = src_data_q;
      src_valid_d  = src_valid_q;
      src_sop_d    = src_sop_q;
      src_eop_d    = src_eop_q;
      src_nbytes_d = src_nbytes_q;
      crc_d        = crc_q;
      crc_valid_d  = 1'b0;
      err_d        = 1'b0;
`ifdef DSI_CRC_APPEND_EN
      tail_d       = tail_q;
      tail_cnt_d   = tail_cnt_q;
`endif

      if (out_free) src_valid_d = 1'b0;

      if (accept) begin
         if (state_q == ST_IDLE && !snk_sop_i) begin
            // Orphan beat: consumed and dropped.
            err_d = 1'b1;
         end else begin
            err_d        = (state_q == ST_PKT) && snk_sop_i;
            crc_run_d    = crc_fold;
            src_valid_d  = 1'b1;
            src_data_d   = snk_data_i;
            src_sop_d    = snk_sop_i;
            src_eop_d    = snk_eop_i;
            src_nbytes_d = snk_eop_i ? n_eff : LANES4;
            state_d      = ST_PKT;
            if (snk_eop_i) begin
               crc_d       = crc_fold;
               crc_valid_d = 1'b1;
               state_d     = ST_IDLE;
`ifdef DSI_CRC_APPEND_EN
               if (5'(n_eff) + 5'd2 <= 5'(LANES4)) begin
                  for (int k = 0; k < g_lanes; k++) begin
                     if (4'(k) == n_eff)        src_data_d[8*k +: 8] = crc_fold[7:0];
                     if (4'(k) == n_eff + 4'd1) src_data_d[8*k +: 8] = crc_fold[15:8];
                  end
                  src_nbytes_d = n_eff + 4'd2;
               end else begin
                  // CRC does not fit: spill the remainder into a trailing beat.
                  src_eop_d    = 1'b0;
                  src_nbytes_d = LANES4;
                  state_d      = ST_TAIL;
                  if (n_eff < LANES4) begin
                     for (int k = 0; k < g_lanes; k++) begin
                        if (4'(k) == n_eff) src_data_d[8*k +: 8] = crc_fold[7:0];
                     end
                     tail_d     = {8'h00, crc_fold[15:8]};
                     tail_cnt_d = 2'd1;
                  end else begin
                     tail_d     = crc_fold;
                     tail_cnt_d = 2'd2;
                  end
               end
`endif
            end
         end
      end

`ifdef DSI_CRC_APPEND_EN
      if (state_q == ST_TAIL && out_free) begin
         src_valid_d = 1'b1;
         src_sop_d   = 1'b0;
         src_data_d  = '0;
         for (int k = 0; k < ((g_lanes < 2) ? g_lanes : 2); k++) begin
            src_data_d[8*k +: 8] = tail_q[8*k +: 8];
         end
         if (g_lanes >= 2 || tail_cnt_q == 2'd1) begin
            src_eop_d    = 1'b1;
            src_nbytes_d = {2'b00, tail_cnt_q};
            state_d      = ST_IDLE;
         end else begin
            src_eop_d    = 1'b0;
            src_nbytes_d = LANES4;
            tail_d       = tail_q >> 8;
            tail_cnt_d   = tail_cnt_q - 2'd1;
         end
      end
`endif
   end

   // NOTE: all state, including data registers, is cleared by the async reset so nothing stale leaks out.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= ST_IDLE;
         crc_run_q    <= g_crc_init;
         src_data_q   <= '0;
         src_valid_q  <= 1'b0;
         src_sop_q    <= 1'b0;
         src_eop_q    <= 1'b0;
         src_nbytes_q <= 4'd0;
         crc_q        <= 16'h0000;
         crc_valid_q  <= 1'b0;
         err_q        <= 1'b0;
`ifdef DSI_CRC_APPEND_EN
         tail_q       <= 16'h0000;
         tail_cnt_q   <= 2'd0;
`endif
      end else begin
         // NOTE: non-blocking updates so every register samples pre-edge values.
         state_q      <= state_d;
         crc_run_q    <= crc_run_d;
         src_data_q   <= src_data_d;
         src_valid_q  <= src_valid_d;
         src_sop_q    <= src_sop_d;
         src_eop_q    <= src_eop_d;
         src_nbytes_q <= src_nbytes_d;
         crc_q        <= crc_d;
         crc_valid_q  <= crc_valid_d;
         err_q        <= err_d;
`ifdef DSI_CRC_APPEND_EN
         tail_q       <= tail_d;
         tail_cnt_q   <= tail_cnt_d;
`endif
      end
   end

   assign src_data_o   = src_data_q;
   assign src_valid_o  = src_valid_q;
   assign src_sop_o    = src_sop_q;
   assign src_eop_o    = src_eop_q;
   assign src_nbytes_o = src_nbytes_q;
   assign crc_o        = crc_q;
   assign crc_valid_o  = crc_valid_q;
   assign err_o        = err_q;

endmodule

// File: tb/tb_dsi_crc_stream.sv
// Directed bench for dsi_crc_stream (g_lanes=4); expectations follow DSI_CRC_APPEND_EN when defined.
module tb_dsi_crc_stream;

   localparam int L = 4;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [8*L-1:0] snk_data_i;
   logic           snk_valid_i, snk_sop_i, snk_eop_i;
   logic [3:0]     snk_nbytes_i;
   logic           snk_ready_o;
   logic [8*L-1:0] src_data_o;
   logic           src_valid_o, src_sop_o, src_eop_o;
   logic [3:0]     src_nbytes_o;
   logic           src_ready_i;
   logic [15:0]    crc_o;
   logic           crc_valid_o, err_o;

   dsi_crc_stream #(.g_lanes(L), .g_crc_init(16'hFFFF)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .snk_data_i(snk_data_i), .snk_valid_i(snk_valid_i), .snk_ready_o(snk_ready_o),
      .snk_sop_i(snk_sop_i), .snk_eop_i(snk_eop_i), .snk_nbytes_i(snk_nbytes_i),
      .src_data_o(src_data_o), .src_valid_o(src_valid_o), .src_ready_i(src_ready_i),
      .src_sop_o(src_sop_o), .src_eop_o(src_eop_o), .src_nbytes_o(src_nbytes_o),
      .crc_o(crc_o), .crc_valid_o(crc_valid_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   // Beat encoding: {data, sop, eop, nbytes}
   localparam logic [37:0] P1_B0 = {32'h34333231, 1'b1, 1'b0, 4'd4};
   localparam logic [37:0] P1_B1 = {32'h38373635, 1'b0, 1'b0, 4'd4};
`ifdef DSI_CRC_APPEND_EN
   localparam logic [37:0] P1_B2   = {32'h006F9139, 1'b0, 1'b1, 4'd3};
   localparam logic [37:0] Z_BEAT  = {32'h0000FFFF, 1'b1, 1'b1, 4'd2};
   localparam logic [37:0] P3_B2   = {32'h016F9139, 1'b0, 1'b0, 4'd4};
   localparam logic [37:0] P3_TAIL = {32'h00001189, 1'b0, 1'b1, 4'd2};
   localparam int          P3_N    = 4;
   localparam int          P3_RLOW = 1;
`else
   localparam logic [37:0] P1_B2   = {32'h00000039, 1'b0, 1'b1, 4'd1};
   localparam logic [37:0] Z_BEAT  = {32'h00000000, 1'b1, 1'b1, 4'd0};
   localparam logic [37:0] P3_B2   = {32'h016F9139, 1'b0, 1'b1, 4'd4};
   localparam int          P3_N    = 3;
   localparam int          P3_RLOW = 0;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   // Monitor: records handshaken source beats and counts pulses, sampled on the falling edge.
   logic [37:0] rx_mem [0:255];
   int          rx_cnt = 0, crc_pulses = 0, err_pulses = 0, ready_low = 0;
   int          hold_viol = 0, cv_viol = 0;
   logic        prev_stall = 1'b0;
   logic [37:0] prev_beat = '0;
   wire  [37:0] cur_beat = {src_data_o, src_sop_o, src_eop_o, src_nbytes_o};

   always @(negedge clk) begin
      if (rst_n) begin
         if (src_valid_o && src_ready_i) begin
            rx_mem[rx_cnt[7:0]] <= cur_beat;
            rx_cnt <= rx_cnt + 1;
         end
         if (crc_valid_o) crc_pulses <= crc_pulses + 1;
         if (crc_valid_o && !src_valid_o) cv_viol <= cv_viol + 1;
         if (err_o) err_pulses <= err_pulses + 1;
         if (!snk_ready_o && src_ready_i) ready_low <= ready_low + 1;
         if (prev_stall && (!src_valid_o || cur_beat != prev_beat)) hold_viol <= hold_viol + 1;
         prev_stall <= src_valid_o && !src_ready_i;
         prev_beat  <= cur_beat;
      end else begin
         prev_stall <= 1'b0;
      end
   end

   logic rand_mode = 1'b0;
   initial begin
      src_ready_i = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         src_ready_i = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic send(input logic [31:0] d, input logic sop, input logic eop, input logic [3:0] nb);
      bit ok = 0;
      snk_data_i = d; snk_sop_i = sop; snk_eop_i = eop; snk_nbytes_i = nb; snk_valid_i = 1'b1;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (snk_ready_o) begin ok = 1; break; end
      end
      if (!ok) check("snk_ready_timeout", 0, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      snk_valid_i = 1'b0; snk_sop_i = 1'b0; snk_eop_i = 1'b0; snk_nbytes_i = 4'd0; snk_data_i = '0;
   endtask

   task automatic drain();
      bit ok = 0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (!src_valid_o && snk_ready_o) begin ok = 1; break; end
      end
      if (!ok) check("drain_timeout", 0, 1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic send_p1();   // "123456789"
      send(32'h34333231, 1'b1, 1'b0, 4'd4);
      send(32'h38373635, 1'b0, 1'b0, 4'd4);
      send(32'h00000039, 1'b0, 1'b1, 4'd1);
   endtask

   task automatic send_p3();   // "123456789" 91 6F 01 -> CRC 0x1189
      send(32'h34333231, 1'b1, 1'b0, 4'd4);
      send(32'h38373635, 1'b0, 1'b0, 4'd4);
      send(32'h016F9139, 1'b0, 1'b1, 4'd4);
   endtask

   int rb, cb, eb, lb;
   logic [37:0] exp_q [$];

   initial begin
      rst_n = 1'b0;
      idle();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_src_valid", src_valid_o, 0);
      check("rst_src_sop", src_sop_o, 0);
      check("rst_src_eop", src_eop_o, 0);
      check("rst_src_nbytes", src_nbytes_o, 0);
      check("rst_src_data", src_data_o, 0);
      check("rst_crc", crc_o, 0);
      check("rst_crc_valid", crc_valid_o, 0);
      check("rst_err", err_o, 0);
      check("rst_snk_ready", snk_ready_o, 1);
      @(posedge clk); #1;

      // Check string, ready held high
      rb = rx_cnt; cb = crc_pulses;
      send_p1(); idle(); drain();
      check("p1_beats", rx_cnt - rb, 3);
      check("p1_b0", rx_mem[rb], P1_B0);
      check("p1_b1", rx_mem[rb+1], P1_B1);
      check("p1_b2", rx_mem[rb+2], P1_B2);
      check("p1_crc", crc_o, 16'h6F91);
      check("p1_crc_pulses", crc_pulses - cb, 1);

      // Zero-length packet
      rb = rx_cnt; cb = crc_pulses;
      send(32'h00000000, 1'b1, 1'b1, 4'd0); idle(); drain();
      check("zl_beats", rx_cnt - rb, 1);
      check("zl_beat", rx_mem[rb], Z_BEAT);
      check("zl_crc", crc_o, 16'hFFFF);
      check("zl_crc_pulses", crc_pulses - cb, 1);

      // Full last beat
      rb = rx_cnt; cb = crc_pulses; lb = ready_low;
      send_p3(); idle(); drain();
      check("p3_beats", rx_cnt - rb, P3_N);
      check("p3_b2", rx_mem[rb+2], P3_B2);
`ifdef DSI_CRC_APPEND_EN
      check("p3_tail", rx_mem[rb+3], P3_TAIL);
`endif
      check("p3_crc", crc_o, 16'h1189);
      check("p3_ready_low", ready_low - lb, P3_RLOW);

      // Random backpressure: same stream expected
      rb = rx_cnt; cb = crc_pulses;
      exp_q = {P1_B0, P1_B1, P1_B2, P1_B0, P1_B1, P3_B2};
`ifdef DSI_CRC_APPEND_EN
      exp_q.push_back(P3_TAIL);
`endif
      rand_mode = 1'b1;
      send_p1(); send_p3(); idle(); drain();
      rand_mode = 1'b0;
      @(posedge clk); #1;
      check("rnd_beats", rx_cnt - rb, exp_q.size());
      foreach (exp_q[i]) check($sformatf("rnd_b%0d", i), rx_mem[rb+i], exp_q[i]);
      check("rnd_crc", crc_o, 16'h1189);
      check("rnd_crc_pulses", crc_pulses - cb, 2);
      check("rnd_hold", hold_viol, 0);

      // Orphan beat in IDLE
      rb = rx_cnt; cb = crc_pulses; eb = err_pulses;
      send(32'hDEADBEEF, 1'b0, 1'b0, 4'd4); idle(); drain();
      check("orph_err", err_pulses - eb, 1);
      check("orph_beats", rx_cnt - rb, 0);
      check("orph_crc_pulses", crc_pulses - cb, 0);

      // sop inside a packet restarts the CRC
      rb = rx_cnt; cb = crc_pulses; eb = err_pulses;
      send(32'hAABBCCDD, 1'b1, 1'b0, 4'd4);
      send_p1(); idle(); drain();
      check("resop_err", err_pulses - eb, 1);
      check("resop_crc_pulses", crc_pulses - cb, 1);
      check("resop_crc", crc_o, 16'h6F91);
      check("resop_beats", rx_cnt - rb, 4);
      check("resop_b0", rx_mem[rb], {32'hAABBCCDD, 1'b1, 1'b0, 4'd4});

      // Async reset mid-packet
      send(32'h11223344, 1'b1, 1'b0, 4'd4);
      send(32'h55667788, 1'b0, 1'b0, 4'd4);
      idle();
      #2 rst_n = 1'b0;
      #1;
      check("mrst_src_valid", src_valid_o, 0);
      check("mrst_src_data", src_data_o, 0);
      check("mrst_src_sop", src_sop_o, 0);
      check("mrst_crc", crc_o, 0);
      check("mrst_crc_valid", crc_valid_o, 0);
      check("mrst_snk_ready", snk_ready_o, 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      rb = rx_cnt; cb = crc_pulses;
      send_p1(); idle(); drain();
      check("mrst_p1_crc", crc_o, 16'h6F91);
      check("mrst_p1_pulses", crc_pulses - cb, 1);
      check("mrst_p1_b0", rx_mem[rb], P1_B0);
      check("crc_valid_with_src_beat", cv_viol, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/dsi_crc_stream.md
# dsi_crc_stream

Streaming, byte-parallel DSI long-packet payload CRC engine with valid/ready handshake on both sides. It processes g_lanes payload bytes per clock, tracks packet framing (sop/eop/partial last beat), and reports the 16-bit payload checksum per packet. Optionally it appends the two checksum bytes to the outgoing stream. It sits between the pixel/command packer and the lane serialiser in the DSI host core, replacing the fixed-width, unhandshaked CRC helper.

## Interface
- g_lanes, 4, payload bytes per beat; legal values 1..8.
- g_crc_init, 16'hFFFF, CRC register value at every sop.
- clk_i  in  1  clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- snk_data_i  in  8*g_lanes  payload; byte k = bits [8k+7:8k]; byte 0 is first on the wire.
- snk_valid_i  in  1  sink beat valid.
- snk_ready_o  out  1  sink beat accepted when valid & ready.
- snk_sop_i  in  1  first beat of packet.
- snk_eop_i  in  1  last beat of packet.
- snk_nbytes_i  in  4  valid bytes on eop beat, 0..g_lanes (bytes 0..n-1); ignored (full beat) when !eop.
- src_data_o  out  8*g_lanes  forwarded data.
- src_valid_o  out  1  source beat valid.
- src_ready_i  in  1  downstream ready.
- src_sop_o, src_eop_o  out  1 each  forwarded framing.
- src_nbytes_o  out  4  valid bytes on src eop beat.
- crc_o  out  16  final CRC of last completed packet; crc_o[7:0] is first transmitted CRC byte.
- crc_valid_o  out  1  one-cycle pulse when crc_o updates.
- err_o  out  1  one-cycle framing-error pulse.

## Operation
- CRC: polynomial x^16+x^12+x^5+1, reflected (LSB of each byte first), no final XOR. Per beat, g_lanes chained byte stages; only bytes 0..n-1 update the register on the eop beat.
- States: IDLE, PKT, TAIL (TAIL exists only with the append feature).
- IDLE: accepted beat with sop → CRC = g_crc_init folded with the beat, forward, go to PKT. sop&eop on the same beat completes the packet immediately. Accepted beat without sop → err_o pulse, beat dropped (consumed, not forwarded), stay IDLE.
- PKT: beat without sop → fold and forward. eop → crc_o loaded, crc_valid_o pulses, go to IDLE (or TAIL). Beat with sop → err_o pulse, current packet abandoned (no crc_valid_o), CRC restarted from g_crc_init with this beat.
- Zero-length packet (sop&eop, nbytes 0) → crc_o = g_crc_init.
- Output stage: single register. snk_ready_o = (!src_valid_o | src_ready_i) & state != TAIL. Source holds data/framing stable while valid & !ready.

## Timing
- Reset: src_valid_o 0, src_sop_o/src_eop_o 0, src_nbytes_o 0, src_data_o 0, crc_o 16'h0000, crc_valid_o 0, err_o 0, state IDLE; snk_ready_o 1.
- Latency: sink accept at edge N → src beat valid after edge N; crc_valid_o high in the cycle after the eop accept edge, concurrent with the src eop beat becoming valid.
- Full throughput of one beat per cycle when src_ready_i is held high (without the append feature).
- Reset mid-packet discards all state; the first post-reset beat must carry sop.

## Configuration
- DSI_CRC_APPEND_EN defined: CRC bytes are appended after the payload. If nbytes+2 ≤ g_lanes, they are placed at bytes n, n+1 of the eop beat and src_nbytes_o = n+2. Otherwise, the eop beat is sent without src_eop_o, followed by a TAIL beat carrying the remaining CRC byte(s) at byte 0 (and 1) with src_eop_o set. snk_ready_o is 0 during TAIL.
- Not defined: the payload is forwarded unchanged; the CRC is available only on crc_o. The TAIL state is not built.

## Test plan
- g_lanes=4, payload "123456789" (0x31..0x39), 3 beats, last nbytes=1 → crc_o=16'h6F91, crc_valid_o one pulse.
- sop&eop, nbytes=0 → crc_o=16'hFFFF; with append, src beat nbytes=2, bytes FF,FF.
- Append, g_lanes=4, "123456789" → eop beat bytes 39,91,6F with nbytes=3. With 4-byte "1234" → extra TAIL beat with 2 bytes; snk_ready_o low one cycle.
- src_ready_i toggled randomly 50% → output stream identical to the ready-high run; no beat lost or duplicated.
- Non-sop beat in IDLE → err_o pulse, no src beat. sop mid-packet → err_o pulse, no crc_valid_o for the abandoned packet, new packet CRC correct.
- rst_n_i asserted mid-packet → all outputs at reset values immediately; the next sop packet gives a correct CRC.
